// File: rtl/serial_demux_pkg.sv
// Shared types and constants for the serial_demux32 block.
// The state encoding and word geometry live here so the decoder,
// the top level and any future siblings agree on them.
package serial_demux_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 5;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/demux_dec5.sv
// 5-to-32 one-hot decoder used as the per-bit write enable of the
// serial demultiplexer. With en low every output bit stays low.
module demux_dec5
   import serial_demux_pkg::*;
(
   input  logic [SEL_W-1:0]  idx,
   input  logic              en,
   output logic [DATA_W-1:0] onehot
);

   // Raise exactly one enable line for the addressed bit position.
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/serial_demux32.sv
// Serial-to-parallel demultiplexer: bits arrive one at a time and are
// written either at an internal auto-incrementing pointer or at an
// explicit position, until every one of the 32 positions has been
// written at least once. The finished word is then held until the
// consumer takes it.
// Optional feature: define SERIAL_DEMUX_PARITY_EN to add out_parity,
// the XOR of the completed word captured on entry to HOLD.
module serial_demux32
   import serial_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [SEL_W-1:0]  sel,
   input  logic              auto_inc,
   input  logic              clear,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
`ifdef SERIAL_DEMUX_PARITY_EN
   output logic              out_parity,
`endif
   input  logic              out_ready
);

   state_t              state;
   state_t              next_state;
   logic [DATA_W-1:0]   mask;
   logic [SEL_W-1:0]    ptr;
   logic [SEL_W-1:0]    pos;
   logic                wr;
   logic [DATA_W-1:0]   wr_oh;
   logic [DATA_W-1:0]   out_next;
   logic                done;
   logic                restart;

   // Handshake outputs come straight from the state register.
   assign din_ready = (state == FILL);
   assign out_valid = (state == HOLD);

   // A write happens only while filling, and an abort suppresses it.
   assign pos      = auto_inc ? ptr : sel;
   assign wr       = din_valid && (state == FILL) && !clear;
   assign out_next = (out & ~wr_oh) | ({DATA_W{din}} & wr_oh);

   // The frame is complete when this write fills the last unset position,
   // independent of which addressing mode produced each bit.
   assign done    = wr && (&(mask | wr_oh));
   assign restart = clear || ((state == HOLD) && out_ready);

   demux_dec5 u_dec (
      .idx    (pos),
      .en     (wr),
      .onehot (wr_oh)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; an abort always returns to FILL and wins over everything.
   always_comb begin
      next_state = state;
      unique case (state)
         FILL: if (done)      next_state = HOLD;
         HOLD: if (out_ready) next_state = FILL;
         default:             next_state = FILL;
      endcase
      if (clear) begin
         next_state = FILL;
      end
   end

   // Data word: written bits replace their position, everything else holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= '0;
      end else begin
         out <= out_next;
      end
   end

   // Written-position tracking and the auto pointer, both reset when a frame ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask <= '0;
         ptr  <= '0;
      end else if (restart) begin
         mask <= '0;
         ptr  <= '0;
      end else begin
         mask <= mask | wr_oh;
         if (wr && auto_inc) begin
            ptr <= ptr + SEL_W'(1);
         end
      end
   end

`ifdef SERIAL_DEMUX_PARITY_EN
   // Parity is captured from the completed word on the edge that enters HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_parity <= 1'b0;
      end else if ((state == FILL) && (next_state == HOLD)) begin
         out_parity <= ^out_next;
      end
   end
`endif

endmodule

// File: tb/tb_serial_demux32.sv
// Self-checking bench for serial_demux32. A behavioural model tracks the
// word as an array of written positions and a count of distinct writes;
// directed frames cover the main scenarios and a randomized phase mixes
// modes, aborts and consumer back-pressure.
// Parity checks are compiled in when SERIAL_DEMUX_PARITY_EN is defined.
module tb_serial_demux32;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        din_valid;
   logic        din_ready;
   logic [4:0]  sel;
   logic        auto_inc;
   logic        clear;
   logic [31:0] out;
   logic        out_valid;
   logic        out_ready;
`ifdef SERIAL_DEMUX_PARITY_EN
   logic        out_parity;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] m_out;
   bit          m_set [32];
   int          m_cnt;
   int          m_ptr;
   bit          m_hold;
   bit          m_par;

   serial_demux32 dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sel        (sel),
      .auto_inc   (auto_inc),
      .clear      (clear),
      .out        (out),
      .out_valid  (out_valid),
`ifdef SERIAL_DEMUX_PARITY_EN
      .out_parity (out_parity),
`endif
      .out_ready  (out_ready)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_out  = '0;
      foreach (m_set[i]) m_set[i] = 1'b0;
      m_cnt  = 0;
      m_ptr  = 0;
      m_hold = 1'b0;
      m_par  = 1'b0;
   endtask

   task automatic modelAbandon();
      foreach (m_set[i]) m_set[i] = 1'b0;
      m_cnt  = 0;
      m_ptr  = 0;
      m_hold = 1'b0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic modelEdge();
      int p;
      if (clear) begin
         modelAbandon();
      end else if (!m_hold) begin
         if (din_valid) begin
            p = auto_inc ? m_ptr : int'(sel);
            m_out[p] = din;
            if (!m_set[p]) begin
               m_set[p] = 1'b1;
               m_cnt++;
            end
            if (auto_inc) m_ptr = (m_ptr + 1) % 32;
            if (m_cnt == 32) begin
               m_hold = 1'b1;
               m_par  = ^m_out;
            end
         end
      end else if (out_ready) begin
         modelAbandon();
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".out"}, out, m_out);
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
      checkOutput({tag, ".din_ready"}, 32'(din_ready), 32'(!m_hold));
`ifdef SERIAL_DEMUX_PARITY_EN
      if (m_hold) checkOutput({tag, ".out_parity"}, 32'(out_parity), 32'(m_par));
`endif
   endtask

   // Drive one cycle of inputs, step model and DUT, then compare after the edge.
   task automatic applyStimulus(input bit dv, input bit d, input int s, input bit ai,
                                input bit clr, input bit ordy, input string tag);
      din_valid = dv;
      din       = d;
      sel       = 5'(s);
      auto_inc  = ai;
      clear     = clr;
      out_ready = ordy;
      modelEdge();
      @(posedge clk);
      #1;
      checkState(tag);
   endtask

   task automatic sendAutoWord(input logic [31:0] w, input string tag);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, w[i], 0, 1'b1, 1'b0, 1'b0, tag);
      end
   endtask

   initial begin
      logic [31:0] word;
      rst       = 1'b1;
      din       = 1'b0;
      din_valid = 1'b0;
      sel       = '0;
      auto_inc  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkState("reset");
      rst = 1'b0;

      // Auto-increment frame, LSB first, consumer stalled.
      word = 32'hA5A5_F00F;
      sendAutoWord(word, "auto");
      checkOutput("auto_word", out, 32'hA5A5_F00F);
      checkOutput("auto_valid", 32'(out_valid), 32'd1);
      checkOutput("auto_ready", 32'(din_ready), 32'd0);

      // Held word ignores incoming bits, then the consumer releases it.
      repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "hold_ignore");
      checkOutput("hold_keep", out, 32'hA5A5_F00F);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, "hold_release");

      // Addressed frame, positions 31 down to 0 with a zero rewrite at 5.
      for (int s = 31; s >= 0; s--) begin
         applyStimulus(1'b1, 1'b1, s, 1'b0, 1'b0, 1'b0, "addr");
         if (s == 5) applyStimulus(1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, "addr_dup");
      end
      checkOutput("addr_word", out, 32'hFFFF_FFDF);
      checkOutput("addr_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "addr_release");

      // Ten bits, then an abort together with a valid bit, then a full frame.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'($urandom), 0, 1'b1, 1'b0, 1'b0, "pre_clear");
      end
      applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, "clear");
      word = $urandom;
      sendAutoWord(word, "post_clear");
      checkOutput("post_clear_word", out, word);
      checkOutput("post_clear_valid", 32'(out_valid), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, "post_clear_release");

      // Asynchronous reset between edges in the middle of a frame.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, "pre_rst");
      end
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_out", out, 32'd0);
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_ready", 32'(din_ready), 32'd1);
      modelReset();
      #1;
      rst = 1'b0;

      // Randomized mix of modes, gaps, aborts and consumer readiness.
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 31)),
                       $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0,
                       $urandom_range(0, 3) == 0, "random");
      end

`ifdef SERIAL_DEMUX_PARITY_EN
      // Parity of known frames.
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, "par_abort");
      sendAutoWord(32'h0000_0007, "par7");
      checkOutput("par7_parity", 32'(out_parity), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, "par_release");
      sendAutoWord(32'h0000_0003, "par3");
      checkOutput("par3_parity", 32'(out_parity), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_demux32.md
SERIAL_DEMUX32 -- requirements
Module: serial_demux32

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port din, input, 1 bit: serial data bit.
REQ-005 SHALL have port din_valid, input, 1 bit: din present.
REQ-006 SHALL have port din_ready, output, 1 bit: block accepts din.
REQ-007 SHALL have port sel, input, 5 bits: target bit position in addressed mode.
REQ-008 SHALL have port auto_inc, input, 1 bit: 1 = internal pointer selects the position, 0 = sel selects it.
REQ-009 SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-010 SHALL have port out, output, 32 bits: assembled word.
REQ-011 SHALL have port out_valid, output, 1 bit: word complete.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts word.

Function
REQ-013 SHALL use two states: FILL (accepting bits) and HOLD (word complete, awaiting consumer).
REQ-014 SHALL drive din_ready = (state == FILL) and out_valid = (state == HOLD), both decoded from registered state only.
REQ-015 SHALL accept a bit on a rising edge when din_valid && din_ready; this write sets out[p] = din and sets mask[p] = 1.
REQ-016 SHALL take p from sel when auto_inc = 0, and from the internal pointer ptr when auto_inc = 1.
REQ-017 SHALL increment ptr on each accepted bit in auto_inc mode; ptr wraps from 31 to 0; ptr is unchanged in addressed mode.
REQ-018 SHALL, on a rewrite of an already-set position, overwrite the data bit and leave mask unchanged.
REQ-019 SHALL, on the accepting edge where mask becomes all-ones, transition FILL -> HOLD, so out_valid = 1 in the next cycle (one-cycle latency).
REQ-020 SHALL update out in the cycle after the accepting edge; out holds its value in HOLD.
REQ-021 SHALL, in HOLD with out_ready = 1, transition HOLD -> FILL, clear mask, set ptr = 0, and retain out.
REQ-022 SHALL ignore din_valid in HOLD (din_ready = 0); no write occurs.
REQ-023 SHALL, on clear = 1 in either state, go to FILL, clear mask, set ptr = 0, and retain out; clear has priority over a simultaneous write or out_ready.
REQ-024 SHALL accept an auto_inc change mid-frame; completion depends on mask alone, regardless of mode.

Reset
REQ-025 SHALL, with rst asserted, immediately force state = FILL, out = 0, mask = 0, ptr = 0, giving out_valid = 0 and din_ready = 1.
REQ-026 SHALL discard a partial or held frame when rst is asserted mid-operation.

Configuration
REQ-027 SHALL, when macro SERIAL_DEMUX_PARITY_EN is defined, add output port out_parity (1 bit) = registered XOR of out, updated on the HOLD-entry edge, reset to 0, and valid whenever out_valid = 1.
REQ-028 SHALL, when SERIAL_DEMUX_PARITY_EN is undefined, omit the out_parity port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the state typedef (FILL, HOLD) and constants DATA_W = 32 and SEL_W = 5 in shared package serial_demux_pkg.
REQ-030 SHALL implement the 5-to-32 one-hot write-enable decode in sub-module demux_dec5 (inputs: 5-bit index and enable; output: 32-bit one-hot), instantiated once.

Verification
REQ-031 Auto mode, 32 bits of 0xA5A5_F00F sent LSB-first with din_valid held and out_ready = 0 -> out = 0xA5A5F00F, out_valid = 1 exactly one cycle after the 32nd accepted bit, and din_ready = 0.
REQ-032 Addressed mode, bit 1 written to sel = 31, 30, ..., 0 with one duplicate write to sel = 5 of 0 -> completion on the 32nd distinct position; out[5] = 0.
REQ-033 In HOLD, pulse din_valid with din = 0, then assert out_ready -> out unchanged, then FILL with ptr = 0 and mask = 0.
REQ-034 Write 10 bits, then assert clear together with din_valid -> no write, mask = 0, and a following 32-bit frame completes normally.
REQ-035 Assert rst asynchronously mid-frame (between edges) -> out = 0, out_valid = 0, din_ready = 1 before the next edge.
REQ-036 With SERIAL_DEMUX_PARITY_EN defined, frame 0x0000_0007 -> out_parity = 1; frame 0x0000_0003 -> out_parity = 0.
